// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg -- shared types and constants for the OBI RAM arbiter.
//   req_id_e     : requester identifier carried through the response ID FIFO
//   INSTR_*      : address-phase values driven for instruction fetches
//   ptr_width()  : FIFO pointer width for a given depth (at least 1 bit)
package obi_arb_pkg;

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } req_id_e;

  localparam logic        INSTR_WE    = 1'b0;
  localparam logic [3:0]  INSTR_BE    = 4'hF;
  localparam logic [31:0] INSTR_WDATA = 32'h0;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo -- in-order FIFO of requester IDs for accepted memory
// transactions. The head names the owner of the next memory response.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i, id_i    : enqueue the ID of a transaction accepted this cycle
//   pop_i           : dequeue the head (response returned this cycle)
//   head_o          : ID at the head of the FIFO
//   empty_o, full_o : occupancy flags
// A pop and a push in the same cycle are legal even when full: the head is
// consumed combinationally this cycle, so the slot can be overwritten at
// the same edge.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  req_id_e id_i,
  input  logic    pop_i,
  output req_id_e head_o,
  output logic    empty_o,
  output logic    full_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] id_mem_q, id_mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      id_mem_d[wr_ptr_q] = id_i;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      id_mem_q <= id_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = req_id_e'(id_mem_q[rd_ptr_q]);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/obi_ram_arbiter.sv
// obi_ram_arbiter -- shares one single-port OBI RAM between an instruction
// requester and a data requester, with up to MAX_OUTSTANDING in-flight
// transactions and in-order response routing.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   instr_*      : OBI instruction requester (read-only)
//   data_*       : OBI data requester
//   mem_*        : shared RAM side, responses return in order
//   err_o        : sticky flag, set by a response with nothing outstanding
// Configuration macro OBI_ARB_DATA_PRIO_EN: when defined, data always wins
// over instr; otherwise the two alternate round-robin. The address-phase
// lock applies in both builds.
module obi_ram_arbiter
  import obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  logic    lock_q, lock_d;
  req_id_e lock_id_q, lock_id_d;
  logic    err_q, err_d;
  req_id_e both_sel;
  req_id_e sel;
  logic    lock_live;
  logic    any_req, room, accept, pop;
  logic    fifo_empty, fifo_full;
  req_id_e fifo_head;

`ifdef OBI_ARB_DATA_PRIO_EN
  assign both_sel = ID_DATA;
`else
  // prio_q names the requester that wins the next contested cycle.
  req_id_e prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      prio_d = (sel == ID_INSTR) ? ID_DATA : ID_INSTR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= ID_INSTR;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign both_sel = prio_q;
`endif

  // A lock only holds while its owner still requests, so a requester that
  // withdraws cannot starve the other side.
  assign lock_live = lock_q && ((lock_id_q == ID_DATA) ? data_req_i : instr_req_i);

  always_comb begin
    sel = ID_INSTR;
    if (lock_live) begin
      sel = lock_id_q;
    end else if (instr_req_i && data_req_i) begin
      sel = both_sel;
    end else if (data_req_i) begin
      sel = ID_DATA;
    end
  end

  // A response this cycle frees a slot, so a full FIFO can still accept.
  assign any_req   = instr_req_i | data_req_i;
  assign pop       = mem_rvalid_i && !fifo_empty && !rst_i;
  assign room      = !fifo_full || pop;
  assign mem_req_o = any_req && room && !rst_i;
  assign accept    = mem_req_o && mem_gnt_i;

  assign mem_addr_o  = (sel == ID_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (sel == ID_DATA) ? data_we_i    : INSTR_WE;
  assign mem_be_o    = (sel == ID_DATA) ? data_be_i    : INSTR_BE;
  assign mem_wdata_o = (sel == ID_DATA) ? data_wdata_i : INSTR_WDATA;

  assign instr_gnt_o = accept && (sel == ID_INSTR);
  assign data_gnt_o  = accept && (sel == ID_DATA);

  assign instr_rvalid_o = pop && (fifo_head == ID_INSTR);
  assign data_rvalid_o  = pop && (fifo_head == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  assign err_d = err_q | (mem_rvalid_i && fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_INSTR;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .id_i    (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_obi_ram_arbiter.sv
// tb_obi_ram_arbiter -- directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbiter.
module tb_obi_ram_arbiter;

  localparam int MAXO = 2;
`ifdef OBI_ARB_DATA_PRIO_EN
  localparam bit DATA_PRIO = 1'b1;
`else
  localparam bit DATA_PRIO = 1'b0;
`endif

  logic        clk, rst;
  logic        ireq, dreq, dwe, gnt, rv;
  logic [31:0] iaddr, daddr, dwdata, rdata;
  logic [3:0]  dbe;
  logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        mem_req_o, mem_we_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  int errors = 0;
  int checks = 0;

  obi_ram_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (ireq),
    .instr_addr_i   (iaddr),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (dreq),
    .data_addr_i    (daddr),
    .data_we_i      (dwe),
    .data_be_i      (dbe),
    .data_wdata_i   (dwdata),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (gnt),
    .mem_rvalid_i   (rv),
    .mem_rdata_i    (rdata),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs;
    ireq = 0; dreq = 0; dwe = 0; gnt = 0; rv = 0;
    iaddr = 0; daddr = 0; dwdata = 0; dbe = 0; rdata = 0;
  endtask

  // Leaves the bench at a falling edge with rst low; the next rising edge
  // is the first functional cycle.
  task automatic apply_reset;
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1; ireq = 1; dreq = 1; gnt = 1; rv = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: req/ig/dg/irv/drv=%b expected 00000",
               {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err: err_o=%b expected 0", err_o);
    end
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle_req: mem_req_o=%b expected 0", mem_req_o);
    end
  endtask

  task automatic test_round_robin;
    logic exp_data, prev_data;
    prev_data = 0;
    @(negedge clk);
    rst = 1; idle_inputs();
    ireq = 1; dreq = 1; iaddr = 32'h1000; daddr = 32'h2000; gnt = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin rv = 1; rdata = 32'hA000 + k; end
      #1;
      exp_data = DATA_PRIO ? 1'b1 : (k % 2 == 1);
      checks++;
      if ({instr_gnt_o, data_gnt_o} !== {!exp_data, exp_data}) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: ig/dg=%b%b expected %b%b", k, instr_gnt_o, data_gnt_o,
                 !exp_data, exp_data);
      end
      checks++;
      if (mem_addr_o !== (exp_data ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL rr_addr[%0d]: mem_addr_o=%h", k, mem_addr_o);
      end
      if (k > 0) begin
        checks++;
        if ({instr_rvalid_o, data_rvalid_o} !== {!prev_data, prev_data}) begin
          errors++;
          $display("FAIL rr_rvalid[%0d]: irv/drv=%b%b expected %b%b", k, instr_rvalid_o,
                   data_rvalid_o, !prev_data, prev_data);
        end
      end
      prev_data = exp_data;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_lock;
    apply_reset();
    dreq = 1; daddr = 32'h100; dwe = 1; dbe = 4'h3; dwdata = 32'h55; gnt = 0;
    iaddr = 32'h400;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) ireq = 1;
      if (c == 4) gnt = 1;
      #1;
      checks++;
      if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b1 || mem_req_o !== 1'b1) begin
        errors++;
        $display("FAIL lock_addr[%0d]: addr=%h we=%b req=%b expected 100 1 1", c, mem_addr_o,
                 mem_we_o, mem_req_o);
      end
      checks++;
      if ({instr_gnt_o, data_gnt_o} !== {1'b0, (c == 4)}) begin
        errors++;
        $display("FAIL lock_gnt[%0d]: ig/dg=%b%b expected 0%b", c, instr_gnt_o, data_gnt_o,
                 (c == 4));
      end
      @(negedge clk);
    end
    dreq = 0;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_we_o !== 1'b0 ||
        mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL lock_instr_phase: ig=%b addr=%h we=%b be=%h wdata=%h expected 1 400 0 f 0",
               instr_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_outstanding;
    logic [4:0] exp [5];
    exp[0] = 5'b11000; exp[1] = 5'b11000; exp[2] = 5'b00000;
    exp[3] = 5'b11001; exp[4] = 5'b00000;
    apply_reset();
    dreq = 1; gnt = 1; daddr = 32'h80;
    for (int c = 0; c < 5; c++) begin
      rv = (c == 3);
      #1;
      // fields: mem_req, data_gnt, instr_gnt, instr_rvalid, data_rvalid
      checks++;
      if ({mem_req_o, data_gnt_o, instr_gnt_o, instr_rvalid_o, data_rvalid_o} !== exp[c]) begin
        errors++;
        $display("FAIL outstanding[%0d]: req/dg/ig/irv/drv=%b expected %b", c,
                 {mem_req_o, data_gnt_o, instr_gnt_o, instr_rvalid_o, data_rvalid_o}, exp[c]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_ordering;
    apply_reset();
    ireq = 1; gnt = 1; iaddr = 32'h10;
    #1;
    checks++;
    if (instr_gnt_o !== 1'b1) begin
      errors++; $display("FAIL order_ig: instr_gnt_o=%b expected 1", instr_gnt_o);
    end
    @(negedge clk);
    ireq = 0; dreq = 1; daddr = 32'h20;
    #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++; $display("FAIL order_dg: data_gnt_o=%b expected 1", data_gnt_o);
    end
    @(negedge clk);
    dreq = 0; rv = 1; rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL order_first: irv/drv=%b%b rdata=%h expected 10 deadbeef",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    @(negedge clk);
    rdata = 32'h12345678;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b01 || data_rdata_o !== 32'h12345678) begin
      errors++;
      $display("FAIL order_second: irv/drv=%b%b rdata=%h expected 01 12345678",
               instr_rvalid_o, data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_spurious_rvalid;
    apply_reset();
    rv = 1;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      errors++;
      $display("FAIL spurious_rvalid: irv/drv=%b%b expected 00", instr_rvalid_o, data_rvalid_o);
    end
    @(negedge clk);
    rv = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL spurious_err_sticky: err_o=%b expected 1", err_o);
    end
    apply_reset();
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL spurious_err_clear: err_o=%b expected 0", err_o);
    end
  endtask

  task automatic test_reset_inflight;
    apply_reset();
    dreq = 1; gnt = 1;
    @(negedge clk);
    @(negedge clk);
    dreq = 0; gnt = 0;
    rst = 1;
    @(negedge clk);
    rst = 0; dreq = 1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL inflight_req: mem_req_o=%b expected 1", mem_req_o);
    end
    @(negedge clk);
    dreq = 0; rv = 1;
    #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      errors++;
      $display("FAIL inflight_rvalid: irv/drv=%b%b expected 00", instr_rvalid_o, data_rvalid_o);
    end
    @(negedge clk);
    rv = 0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL inflight_err: err_o=%b expected 1", err_o);
    end
    idle_inputs();
  endtask

  // Reference model: a queue of owners of accepted transactions, the side
  // that wins the next tie, and the side whose stalled request must stay put.
  task automatic test_random;
    logic q[$];
    logic prefer_data, stalled, stalled_data;
    logic drop_i, drop_d, pop, room, sel_data, e_req, e_ig, e_dg, e_irv, e_drv;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    prefer_data = 0; stalled = 0; stalled_data = 0; drop_i = 0; drop_d = 0;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (drop_i) ireq = 0;
      if (drop_d) dreq = 0;
      if (!ireq && $urandom_range(0, 2) != 0) begin ireq = 1; iaddr = $urandom; end
      if (!dreq && $urandom_range(0, 2) != 0) begin
        dreq = 1; daddr = $urandom; dwe = 1'($urandom); dbe = 4'($urandom); dwdata = $urandom;
      end
      gnt   = ($urandom_range(0, 3) != 0);
      rv    = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      rdata = $urandom;
      #1;
      pop  = rv && (q.size() > 0);
      room = (q.size() < MAXO) || pop;
      if (stalled && (stalled_data ? dreq : ireq)) sel_data = stalled_data;
      else if (ireq && dreq)                       sel_data = DATA_PRIO ? 1'b1 : prefer_data;
      else                                         sel_data = dreq;
      e_req = (ireq || dreq) && room;
      e_ig  = e_req && gnt && !sel_data;
      e_dg  = e_req && gnt && sel_data;
      e_irv = pop && (q[0] == 1'b0);
      e_drv = pop && (q[0] == 1'b1);
      checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o} !==
          {e_req, e_ig, e_dg, e_irv, e_drv, 1'b0}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: req/ig/dg/irv/drv/err=%b expected %b", cyc,
                 {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o},
                 {e_req, e_ig, e_dg, e_irv, e_drv, 1'b0});
      end
      if (e_req) begin
        e_addr  = sel_data ? daddr  : iaddr;
        e_we    = sel_data ? dwe    : 1'b0;
        e_be    = sel_data ? dbe    : 4'hF;
        e_wdata = sel_data ? dwdata : 32'h0;
        checks++;
        if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e_addr, e_we, e_be, e_wdata}) begin
          errors++;
          $display("FAIL rand_aphase[%0d]: addr=%h we=%b be=%h wdata=%h expected %h %b %h %h",
                   cyc, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, e_addr, e_we, e_be, e_wdata);
        end
      end
      if (pop) begin
        checks++;
        if (instr_rdata_o !== rdata || data_rdata_o !== rdata) begin
          errors++;
          $display("FAIL rand_rdata[%0d]: i=%h d=%h expected %h", cyc, instr_rdata_o,
                   data_rdata_o, rdata);
        end
        void'(q.pop_front());
      end
      if (e_req && gnt) begin
        q.push_back(sel_data);
        prefer_data = !sel_data;
        stalled = 0;
      end else if (e_req) begin
        stalled = 1;
        stalled_data = sel_data;
      end
      drop_i = e_ig;
      drop_d = e_dg;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_ordering();
    test_spurious_rvalid();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obi_ram_arbiter.md
OBI_RAM_ARBITER -- requirements
Module: obi_ram_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning max accepted-but-unanswered memory transactions (legal 1..8).
REQ-002 SHALL have one clock and synchronous active-high reset: clk_i input 1 = rising-edge clock; rst_i input 1 = synchronous active-high reset.
REQ-003 SHALL have instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32 = OBI instruction requester.
REQ-004 SHALL have data_req_i in 1, data_addr_i in 32, data_we_i in 1, data_be_i in 4, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32 = OBI data requester.
REQ-005 SHALL have mem_req_o out 1, mem_addr_o out 32, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32 = shared single-port RAM side, in-order responses.
REQ-006 SHALL have err_o out 1 = sticky protocol error flag.

Function
REQ-007 SHALL drive mem_req_o=1 when any requester is pending and outstanding count < MAX_OUTSTANDING; else 0.
REQ-008 SHALL forward the selected requester's address-phase signals to mem_*; instruction transactions SHALL drive we=0, be=4'hF, wdata=0.
REQ-009 SHALL assert exactly one of instr_gnt_o/data_gnt_o, for the selected requester, only when mem_req_o && mem_gnt_i.
REQ-010 SHALL, when both request and no lock is held, select by round-robin: after an accepted instr transaction data has priority, and vice versa.
REQ-011 SHALL lock the selection while mem_req_o=1 and mem_gnt_i=0, so the address phase stays stable until granted; lock clears on grant.
REQ-012 SHALL update the round-robin pointer only on accepted transactions (mem_req_o && mem_gnt_i).
REQ-013 SHALL push requester ID into an ID FIFO of depth MAX_OUTSTANDING on each accept, and pop on mem_rvalid_i.
REQ-014 SHALL route mem_rvalid_i to the rvalid of the FIFO-head owner in the same cycle (zero latency); rdata outputs SHALL both carry mem_rdata_i.
REQ-015 SHALL leave the count unchanged on simultaneous accept and rvalid; pop-before-push ordering, legal even when full.
REQ-016 SHALL ignore mem_rvalid_i when the FIFO is empty and set err_o (sticky until reset).
REQ-017 SHALL keep FIFO pointers at width clog2(MAX_OUTSTANDING) (min 1) with wrap-around at MAX_OUTSTANDING.

Reset
REQ-018 SHALL, on rst_i high at a clock edge, clear count, FIFO pointers, lock and err_o, and set round-robin priority to instr.
REQ-019 SHALL drive all gnt/rvalid/mem_req_o outputs 0 while rst_i=1; outstanding transactions in flight at reset are discarded.

Configuration
REQ-020 SHALL, when OBI_ARB_DATA_PRIO_EN is defined, replace round-robin with fixed data-over-instr priority (lock of REQ-011 still applies); without it, round-robin per REQ-010.

Structure
REQ-021 SHALL place the requester ID enum (INSTR=0, DATA=1) and the instruction default be/we constants in shared package obi_arb_pkg.
REQ-022 SHALL implement the ID FIFO as sub-module obi_arb_id_fifo.

Verification
REQ-023 Both req at reset release, mem_gnt_i=1 -> cycle 0 instr granted, cycle 1 data, alternating; with OBI_ARB_DATA_PRIO_EN data granted every cycle.
REQ-024 Data req addr 0x100 we=1, mem_gnt_i=0 for 3 cycles while instr req rises -> mem_addr_o stays 0x100, data_gnt_o on cycle 4, instr not granted before.
REQ-025 MAX_OUTSTANDING=2, two accepts, no rvalid -> mem_req_o=0 and no gnt on third request; rvalid+new req same cycle -> accept, count stays 2.
REQ-026 Accept instr then data; rvalid with rdata 0xDEADBEEF then 0x12345678 -> instr_rvalid_o first, data_rvalid_o second, correct rdata, never both.
REQ-027 mem_rvalid_i=1 with empty FIFO -> no requester rvalid, err_o=1 until rst_i pulse.
REQ-028 rst_i asserted with 2 outstanding -> next cycle count 0, late rvalid sets err_o.
